// File: rtl/rs_issue_queue.sv
// rs_issue_queue: multi-entry reservation station for one functional-unit class.
// Entries are allocated from dispatch and woken by tag from NUM_CDB broadcast
// channels. Each cycle the oldest valid entry with both operands ready is
// offered to the execute unit.
//
// Handshakes (both ports): a transfer happens at the rising edge where
// valid && ready are both 1. disp_ready and iss_valid depend only on
// registered state, never on the partner's valid/ready in the same cycle.
module rs_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int ROB_IDX_W = 5,
    parameter int NUM_CDB   = 4,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    input  logic [ROB_IDX_W-1:0]         disp_rd_rob,
    input  logic                         disp_rs1_rdy,
    input  logic [ROB_IDX_W-1:0]         disp_rs1_rob,
    input  logic [31:0]                  disp_rs1_data,
    input  logic                         disp_rs2_rdy,
    input  logic [ROB_IDX_W-1:0]         disp_rs2_rob,
    input  logic [31:0]                  disp_rs2_data,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_idx,
    input  logic [NUM_CDB*32-1:0]        cdb_data,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PAYLOAD_W-1:0]         iss_payload,
    output logic [ROB_IDX_W-1:0]         iss_rd_rob,
    output logic [31:0]                  iss_rs1_data,
    output logic [31:0]                  iss_rs2_data,
    output logic [CNT_W-1:0]             free_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic [DEPTH-1:0]     valid;
    logic [PAYLOAD_W-1:0] payload [DEPTH];
    logic [ROB_IDX_W-1:0] rd_rob  [DEPTH];
    logic [DEPTH-1:0]     rs1_rdy;
    logic [DEPTH-1:0]     rs2_rdy;
    logic [ROB_IDX_W-1:0] rs1_tag [DEPTH];
    logic [ROB_IDX_W-1:0] rs2_tag [DEPTH];
    logic [31:0]          rs1_val [DEPTH];
    logic [31:0]          rs2_val [DEPTH];
    // older[j][i] = 1 when entry i was already resident when entry j arrived
    logic [DEPTH-1:0]     older   [DEPTH];

    // Combinational helpers
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] sel_onehot;
    logic             do_alloc;
    logic             do_issue;
    logic [32:0]      disp_rs1_hit;
    logic [32:0]      disp_rs2_hit;
    logic [32:0]      rs1_hit [DEPTH];
    logic [32:0]      rs2_hit [DEPTH];

    // Tag lookup across all channels; {hit, data}. Lowest channel index wins.
    function automatic logic [32:0] cdb_lookup(
        input logic [ROB_IDX_W-1:0]         tag,
        input logic [NUM_CDB-1:0]           v,
        input logic [NUM_CDB*ROB_IDX_W-1:0] tags,
        input logic [NUM_CDB*32-1:0]        data
    );
        logic [32:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (v[k] && (tags[k*ROB_IDX_W +: ROB_IDX_W] == tag)) begin
                r = {1'b1, data[k*32 +: 32]};
            end
        end
        return r;
    endfunction

    assign disp_ready = (free_count != '0);
    assign do_alloc   = disp_valid && disp_ready && !flush;
    assign do_issue   = iss_valid && iss_ready;

    // Pick the lowest-index free entry for the next allocation
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) alloc_idx = IDX_W'(i);
        end
    end

    // Wakeup matches for the dispatching operands and every resident operand
    always_comb begin
        disp_rs1_hit = cdb_lookup(disp_rs1_rob, cdb_valid, cdb_rob_idx, cdb_data);
        disp_rs2_hit = cdb_lookup(disp_rs2_rob, cdb_valid, cdb_rob_idx, cdb_data);
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit[i] = cdb_lookup(rs1_tag[i], cdb_valid, cdb_rob_idx, cdb_data);
            rs2_hit[i] = cdb_lookup(rs2_tag[i], cdb_valid, cdb_rob_idx, cdb_data);
        end
    end

    // Oldest-ready select: an entry wins when no ready entry is older than it
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = valid[i] && rs1_rdy[i] && rs2_rdy[i];
        end
        for (int j = 0; j < DEPTH; j++) begin
            sel_onehot[j] = rdy_vec[j] && ((older[j] & rdy_vec) == '0);
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (sel_onehot[j]) sel_idx = IDX_W'(j);
        end
    end

    // Issue outputs come straight from registered state and read zero when idle
    always_comb begin
        iss_valid    = |rdy_vec;
        iss_payload  = '0;
        iss_rd_rob   = '0;
        iss_rs1_data = '0;
        iss_rs2_data = '0;
        if (iss_valid) begin
            iss_payload  = payload[sel_idx];
            iss_rd_rob   = rd_rob[sel_idx];
            iss_rs1_data = rs1_val[sel_idx];
            iss_rs2_data = rs2_val[sel_idx];
        end
    end

    // Entry state: wakeup, issue release, allocation, flush, occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            rs1_rdy    <= '0;
            rs2_rdy    <= '0;
            free_count <= CNT_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                payload[i] <= '0;
                rd_rob[i]  <= '0;
                rs1_tag[i] <= '0;
                rs2_tag[i] <= '0;
                rs1_val[i] <= '0;
                rs2_val[i] <= '0;
                older[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && !rs1_rdy[i] && rs1_hit[i][32]) begin
                    rs1_rdy[i] <= 1'b1;
                    rs1_val[i] <= rs1_hit[i][31:0];
                end
                if (valid[i] && !rs2_rdy[i] && rs2_hit[i][32]) begin
                    rs2_rdy[i] <= 1'b1;
                    rs2_val[i] <= rs2_hit[i][31:0];
                end
            end

            if (do_issue) begin
                valid[sel_idx] <= 1'b0;
            end

            if (do_alloc) begin
                valid[alloc_idx]   <= 1'b1;
                payload[alloc_idx] <= disp_payload;
                rd_rob[alloc_idx]  <= disp_rd_rob;
                rs1_tag[alloc_idx] <= disp_rs1_rob;
                rs2_tag[alloc_idx] <= disp_rs2_rob;
                rs1_rdy[alloc_idx] <= disp_rs1_rdy || disp_rs1_hit[32];
                rs2_rdy[alloc_idx] <= disp_rs2_rdy || disp_rs2_hit[32];
                rs1_val[alloc_idx] <= disp_rs1_rdy ? disp_rs1_data : disp_rs1_hit[31:0];
                rs2_val[alloc_idx] <= disp_rs2_rdy ? disp_rs2_data : disp_rs2_hit[31:0];
                older[alloc_idx]   <= valid;
                // A reused slot must not look older than entries that outlived its predecessor
                for (int k = 0; k < DEPTH; k++) begin
                    older[k][alloc_idx] <= 1'b0;
                end
            end

            if (flush) begin
                valid      <= '0;
                free_count <= CNT_W'(DEPTH);
            end else begin
                free_count <= free_count + CNT_W'(do_issue) - CNT_W'(do_alloc);
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed bench for rs_issue_queue with an issue scoreboard.
module tb_rs_issue_queue;

    localparam int DEPTH = 8;
    localparam int RW    = 5;
    localparam int NC    = 4;
    localparam int PW    = 128;
    localparam int CW    = 4;
    localparam int EXP_W = PW + RW + 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            disp_valid;
    logic            disp_ready;
    logic [PW-1:0]   disp_payload;
    logic [RW-1:0]   disp_rd_rob;
    logic            disp_rs1_rdy;
    logic [RW-1:0]   disp_rs1_rob;
    logic [31:0]     disp_rs1_data;
    logic            disp_rs2_rdy;
    logic [RW-1:0]   disp_rs2_rob;
    logic [31:0]     disp_rs2_data;
    logic [NC-1:0]   cdb_valid;
    logic [NC*RW-1:0] cdb_rob_idx;
    logic [NC*32-1:0] cdb_data;
    logic            iss_valid;
    logic            iss_ready;
    logic [PW-1:0]   iss_payload;
    logic [RW-1:0]   iss_rd_rob;
    logic [31:0]     iss_rs1_data;
    logic [31:0]     iss_rs2_data;
    logic [CW-1:0]   free_count;

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp_e;

    rs_issue_queue #(
        .DEPTH(DEPTH), .ROB_IDX_W(RW), .NUM_CDB(NC), .PAYLOAD_W(PW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_payload(disp_payload), .disp_rd_rob(disp_rd_rob),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_rob(disp_rs1_rob), .disp_rs1_data(disp_rs1_data),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_rob(disp_rs2_rob), .disp_rs2_data(disp_rs2_data),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_payload(iss_payload), .iss_rd_rob(iss_rd_rob),
        .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
        .free_count(free_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [PW-1:0] pl, input logic [RW-1:0] rd,
                            input logic r1, input logic [RW-1:0] t1, input logic [31:0] d1,
                            input logic r2, input logic [RW-1:0] t2, input logic [31:0] d2);
        disp_valid    = 1'b1;
        disp_payload  = pl;
        disp_rd_rob   = rd;
        disp_rs1_rdy  = r1;
        disp_rs1_rob  = t1;
        disp_rs1_data = d1;
        disp_rs2_rdy  = r2;
        disp_rs2_rob  = t2;
        disp_rs2_data = d2;
    endtask

    task automatic push_exp(input logic [PW-1:0] pl, input logic [RW-1:0] rd,
                            input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back({pl, rd, a, b});
    endtask

    task automatic bcast(input int ch, input logic [RW-1:0] tag, input logic [31:0] data);
        cdb_valid = '0;
        cdb_rob_idx = '0;
        cdb_data = '0;
        cdb_valid[ch] = 1'b1;
        cdb_rob_idx[ch*RW +: RW] = tag;
        cdb_data[ch*32 +: 32] = data;
    endtask

    // Scoreboard: every accepted issue must match the next expected op
    always @(negedge clk) begin
        if (!rst && !flush && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                chk("iss_unexpected", {iss_payload, iss_rd_rob, iss_rs1_data, iss_rs2_data}, '0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("iss_pkt", {iss_payload, iss_rd_rob, iss_rs1_data, iss_rs2_data}, exp_e);
            end
        end
    end

    initial begin
        logic [31:0] ra [DEPTH];
        logic [31:0] rb [DEPTH];
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        disp_payload = '0; disp_rd_rob = '0;
        disp_rs1_rdy = 1'b0; disp_rs1_rob = '0; disp_rs1_data = '0;
        disp_rs2_rdy = 1'b0; disp_rs2_rob = '0; disp_rs2_data = '0;
        cdb_valid = '0; cdb_rob_idx = '0; cdb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_free_count", free_count, DEPTH);
        chk("rst_iss_payload", iss_payload, 0);
        tick();

        // 1: reset with three resident ready entries
        for (int i = 0; i < 3; i++) begin
            set_disp(PW'(100 + i), RW'(20 + i), 1'b1, '0, 32'(i), 1'b1, '0, 32'(i));
            tick();
        end
        disp_valid = 1'b0;
        @(negedge clk);
        chk("t1_pre_free", free_count, 5);
        chk("t1_pre_iss", iss_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t1_rst_iss", iss_valid, 0);
        chk("t1_rst_free", free_count, DEPTH);
        @(posedge clk);
        #1 rst = 1'b0;

        // 2: ready-at-dispatch op issues one cycle later
        iss_ready = 1'b1;
        set_disp(PW'(2), 5'd3, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
        push_exp(PW'(2), 5'd3, 32'd5, 32'd7);
        @(negedge clk);
        chk("t2_no_iss_alloc_cycle", iss_valid, 0);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        chk("t2_iss_valid", iss_valid, 1);
        chk("t2_free_mid", free_count, 7);
        tick();
        @(negedge clk);
        chk("t2_free_back", free_count, DEPTH);
        tick();

        // 3: younger ready op overtakes older waiting op
        set_disp(PW'(16'hA), 5'd10, 1'b0, 5'd9, 32'd0, 1'b1, '0, 32'd1);
        tick();
        set_disp(PW'(16'hB), 5'd11, 1'b1, '0, 32'd2, 1'b1, '0, 32'd3);
        push_exp(PW'(16'hB), 5'd11, 32'd2, 32'd3);
        @(negedge clk);
        chk("t3_a_waiting", iss_valid, 0);
        tick();
        disp_valid = 1'b0;
        bcast(2, 5'd9, 32'hDEAD);
        push_exp(PW'(16'hA), 5'd10, 32'hDEAD, 32'd1);
        @(negedge clk);
        chk("t3_b_first", iss_rd_rob, 11);
        tick();
        cdb_valid = '0;
        @(negedge clk);
        chk("t3_a_after_bcast", {iss_valid, iss_rd_rob}, {1'b1, 5'd10});
        tick();

        // 4: wakeup captured in the dispatch cycle
        set_disp(PW'(4), 5'd12, 1'b1, '0, 32'h44, 1'b0, 5'd4, 32'd0);
        bcast(0, 5'd4, 32'h11);
        push_exp(PW'(4), 5'd12, 32'h44, 32'h11);
        tick();
        disp_valid = 1'b0;
        cdb_valid = '0;
        @(negedge clk);
        chk("t4_iss_next", {iss_valid, iss_rd_rob}, {1'b1, 5'd12});
        tick();
        @(negedge clk);
        chk("t4_empty", free_count, DEPTH);
        tick();

        // 5: fill, reject overflow, drain oldest first, reuse slot 0 as youngest
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ra[i] = $urandom_range(1, 65535);
            rb[i] = $urandom_range(1, 65535);
            set_disp(PW'(8'h50 + i), RW'(16 + i), 1'b1, '0, ra[i], 1'b1, '0, rb[i]);
            push_exp(PW'(8'h50 + i), RW'(16 + i), ra[i], rb[i]);
            tick();
        end
        set_disp(PW'(8'h99), 5'd31, 1'b1, '0, 32'd9, 1'b1, '0, 32'd9);
        @(negedge clk);
        chk("t5_full_ready", disp_ready, 0);
        chk("t5_full_count", free_count, 0);
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        chk("t5_ignored", free_count, 0);
        tick();
        iss_ready = 1'b1;
        @(negedge clk);
        chk("t5_oldest", iss_rd_rob, 16);
        chk("t5_ready_lag", disp_ready, 0);
        tick();
        set_disp(PW'(8'h5A), 5'd30, 1'b1, '0, 32'h5A, 1'b1, '0, 32'h5B);
        push_exp(PW'(8'h5A), 5'd30, 32'h5A, 32'h5B);
        @(negedge clk);
        chk("t5_ready_back", disp_ready, 1);
        chk("t5_count_one", free_count, 1);
        chk("t5_second", iss_rd_rob, 17);
        tick();
        disp_valid = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        chk("t5_drained", free_count, DEPTH);
        tick();

        // 6: flush drops residents and the same-cycle dispatch
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_disp(PW'(8'h60 + i), RW'(i), 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
            tick();
        end
        set_disp(PW'(8'h6F), 5'd15, 1'b1, '0, 32'd3, 1'b1, '0, 32'd4);
        flush = 1'b1;
        @(negedge clk);
        chk("t6_pre_flush", free_count, 3);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        @(negedge clk);
        chk("t6_free_after", free_count, DEPTH);
        chk("t6_iss_after", iss_valid, 0);
        iss_ready = 1'b1;
        repeat (3) tick();

        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
